// File: rtl/iagu_conv_baddr_if.sv
// rtl/iagu_conv_baddr_if.sv - group-descriptor handshake between address generator and group loader
interface iagu_conv_baddr_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] o_BaseAdder;
  logic [11:0]       o_InputCurCol;
  logic [1:0]        o_PartFlag;
  logic [3:0]        o_KerCol;
  logic [2:0]        o_LastColNum;
  logic              o_GroupStart;
  logic              i_GroupLoadEnd;
  logic              i_Fifo_REn;

  modport master (
    output o_BaseAdder, o_InputCurCol, o_PartFlag, o_KerCol, o_LastColNum, o_GroupStart,
    input  i_GroupLoadEnd, i_Fifo_REn
  );

  modport slave (
    input  o_BaseAdder, o_InputCurCol, o_PartFlag, o_KerCol, o_LastColNum, o_GroupStart,
    output i_GroupLoadEnd, i_Fifo_REn
  );
endinterface

// File: rtl/iagu_conv_baddr.sv
// rtl/iagu_conv_baddr.sv - convolution IOB base-address generator with group-descriptor FIFO
// Walks out row / kernel row / 7-column part / kernel column and queues one descriptor per step.
module iagu_conv_baddr #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_AGUStart,
  input  logic [ADDR_W-1:0] i_IOB_Base,
  input  logic [7:0]        i_Input_XLength,
  input  logic [7:0]        i_OutXLength,
  input  logic [7:0]        i_OutRows,
  input  logic [3:0]        i_KerCol,
  input  logic [3:0]        i_KerRow,
  input  logic [1:0]        i_Stride,
  input  logic [1:0]        i_Pad,
  output logic              o_BaseAdderEndf,
  output logic              o_Busy,
  iagu_conv_baddr_if.master grp
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [7:0]        xlen;
    logic [7:0]        rows;
    logic [3:0]        kcol;
    logic [3:0]        krow;
    logic [1:0]        pad;
    logic [5:0]        nparts;
    logic [2:0]        lastlen;
    logic [9:0]        rstep;   // Stride*Input_XLength
    logic [4:0]        pstep;   // 7*Stride
  } cfg_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [11:0]       col;
    logic [1:0]        flag;
    logic [3:0]        kc;
    logic [2:0]        lc;
  } desc_t;

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [7:0]        r_q, r_d;
  logic [3:0]        kr_q, kr_d;
  logic [5:0]        p_q, p_d;
  logic [3:0]        kc_q, kc_d;
  logic [11:0]       colb_q, colb_d;
  logic [ADDR_W-1:0] rowb_q, rowb_d;
  logic [ADDR_W-1:0] rowo_q, rowo_d;
  logic              issued_q, issued_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       fifo_cnt_q, fifo_cnt_d;
  desc_t             mem_q [FIFO_DEPTH];

  logic        empty, full, push, pop, gstart;
  logic        last_kc, last_p, last_kr, last_r;
  logic [5:0]  nparts_calc;
  logic [7:0]  npm1;
  logic [11:0] cur_col;
  desc_t       wdesc, head;

  assign empty  = (fifo_cnt_q == '0);
  assign full   = fifo_cnt_q[AW];
  assign pop    = grp.i_Fifo_REn && !empty && !i_AGUStart;
  assign push   = (state_q == GEN) && (!full || pop) && !i_AGUStart;
  assign gstart = ((state_q == GEN) || (state_q == DRAIN)) && !empty && grp.i_GroupLoadEnd
                  && !issued_q && !grp.i_Fifo_REn && !i_AGUStart;

  assign last_kc = (kc_q == cfg_q.kcol - 4'd1);
  assign last_p  = (p_q == cfg_q.nparts - 6'd1);
  assign last_kr = (kr_q == cfg_q.krow - 4'd1);
  assign last_r  = (r_q == cfg_q.rows - 8'd1);

  // 7*(n-1) as shift-subtract; modular 8-bit arithmetic still yields the 1..7 remainder
  assign nparts_calc = 6'((9'(i_OutXLength) + 9'd6) / 9'd7);
  assign npm1        = {2'b00, nparts_calc} - 8'd1;

  assign cur_col     = colb_q + {8'b0, kc_q};
  assign wdesc.base  = cfg_q.base + rowo_q + ADDR_W'(cur_col) - ADDR_W'(cfg_q.pad);
  assign wdesc.col   = cur_col;
  assign wdesc.flag  = {p_q == 6'd0, last_p};
  assign wdesc.kc    = kc_q;
  assign wdesc.lc    = last_p ? cfg_q.lastlen : 3'd7;

  assign head = mem_q[rd_q];

  assign grp.o_BaseAdder   = empty ? '0 : head.base;
  assign grp.o_InputCurCol = empty ? '0 : head.col;
  assign grp.o_PartFlag    = empty ? '0 : head.flag;
  assign grp.o_KerCol      = empty ? '0 : head.kc;
  assign grp.o_LastColNum  = empty ? '0 : head.lc;
  assign grp.o_GroupStart  = gstart;
  assign o_BaseAdderEndf   = (state_q == DONE);
  assign o_Busy            = (state_q == GEN) || (state_q == DRAIN);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    r_d        = r_q;
    kr_d       = kr_q;
    p_d        = p_q;
    kc_d       = kc_q;
    colb_d     = colb_q;
    rowb_d     = rowb_q;
    rowo_d     = rowo_q;
    issued_d   = issued_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    fifo_cnt_d = fifo_cnt_q;

    if (i_AGUStart) begin
      state_d       = GEN;
      cfg_d.base    = i_IOB_Base;
      cfg_d.xlen    = i_Input_XLength;
      cfg_d.rows    = i_OutRows;
      cfg_d.kcol    = i_KerCol;
      cfg_d.krow    = i_KerRow;
      cfg_d.pad     = i_Pad;
      cfg_d.nparts  = nparts_calc;
      cfg_d.lastlen = 3'(i_OutXLength - ((npm1 << 3) - npm1));
      cfg_d.rstep   = (i_Stride[0] ? {2'b00, i_Input_XLength} : 10'd0)
                    + (i_Stride[1] ? {1'b0, i_Input_XLength, 1'b0} : 10'd0);
      cfg_d.pstep   = {i_Stride, 3'b000} - {3'b000, i_Stride};
      r_d        = '0;
      kr_d       = '0;
      p_d        = '0;
      kc_d       = '0;
      colb_d     = '0;
      rowb_d     = '0;
      rowo_d     = '0;
      issued_d   = 1'b0;
      wr_d       = '0;
      rd_d       = '0;
      fifo_cnt_d = '0;
    end else begin
      if (pop) begin
        rd_d     = rd_q + PTR_ONE;
        issued_d = 1'b0;
      end else if (gstart) begin
        issued_d = 1'b1;
      end

      if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - CNT_ONE;

      // Innermost kc, then part, then kernel row, then output row
      if (push) begin
        wr_d = wr_q + PTR_ONE;
        if (!last_kc) begin
          kc_d = kc_q + 4'd1;
        end else begin
          kc_d = '0;
          if (!last_p) begin
            p_d    = p_q + 6'd1;
            colb_d = colb_q + 12'(cfg_q.pstep);
          end else begin
            p_d    = '0;
            colb_d = '0;
            if (!last_kr) begin
              kr_d   = kr_q + 4'd1;
              rowo_d = rowo_q + ADDR_W'(cfg_q.xlen);
            end else begin
              kr_d = '0;
              if (last_r) begin
                state_d = DRAIN;
              end else begin
                r_d    = r_q + 8'd1;
                rowb_d = rowb_q + ADDR_W'(cfg_q.rstep);
                rowo_d = rowb_q + ADDR_W'(cfg_q.rstep);
              end
            end
          end
        end
      end

      if ((state_q == DRAIN) && empty && !issued_q) state_d = DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      r_q        <= '0;
      kr_q       <= '0;
      p_q        <= '0;
      kc_q       <= '0;
      colb_q     <= '0;
      rowb_q     <= '0;
      rowo_q     <= '0;
      issued_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      r_q        <= r_d;
      kr_q       <= kr_d;
      p_q        <= p_d;
      kc_q       <= kc_d;
      colb_q     <= colb_d;
      rowb_q     <= rowb_d;
      rowo_q     <= rowo_d;
      issued_q   <= issued_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) mem_q[wr_q] <= wdesc;
  end
endmodule

// File: tb/tb_iagu_conv_baddr.sv
// tb/tb_iagu_conv_baddr.sv - scoreboard bench for the convolution base-address generator
module tb_iagu_conv_baddr;
  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base;
  logic [7:0]  xlen, outx, rows;
  logic [3:0]  kcol, krow;
  logic [1:0]  stride, pad;
  logic        endf, busy;

  iagu_conv_baddr_if #(.ADDR_W(ADDR_W)) gi ();

  iagu_conv_baddr #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_AGUStart(start), .i_IOB_Base(base),
    .i_Input_XLength(xlen), .i_OutXLength(outx), .i_OutRows(rows),
    .i_KerCol(kcol), .i_KerRow(krow), .i_Stride(stride), .i_Pad(pad),
    .o_BaseAdderEndf(endf), .o_Busy(busy), .grp(gi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] base;
    logic [11:0] col;
    logic [1:0]  flag;
    logic [3:0]  kc;
    logic [2:0]  lc;
  } desc_t;

  desc_t exp_q[$];
  desc_t got, last_iss;
  bit    have_iss = 0;
  int    n_total = 0, n_pass = 0, n_issue = 0;

  assign got = {gi.o_BaseAdder, gi.o_InputCurCol, gi.o_PartFlag, gi.o_KerCol, gi.o_LastColNum};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic desc_t mk(input logic [11:0] b, input logic [11:0] c, input logic [1:0] f,
                               input logic [3:0] k, input logic [2:0] l);
    return {b, c, f, k, l};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      have_iss = 0;
    end else begin
      if (gi.i_Fifo_REn && have_iss) begin
        check("hold_until_pop", 64'(got), 64'(last_iss));
        have_iss = 0;
      end
      if (gi.o_GroupStart) begin
        n_issue++;
        check("issue_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("descriptor", 64'(got), 64'(exp_q.pop_front()));
        last_iss = got;
        have_iss = 1;
      end
    end
  end

  task automatic cfg_a();
    base = 12'h100; xlen = 8'd14; outx = 8'd10; rows = 8'd1;
    krow = 4'd1; kcol = 4'd3; stride = 2'd1; pad = 2'd1;
  endtask

  task automatic push_a();
    exp_q.push_back(mk(12'h0FF, 12'd0, 2'b10, 4'd0, 3'd7));
    exp_q.push_back(mk(12'h100, 12'd1, 2'b10, 4'd1, 3'd7));
    exp_q.push_back(mk(12'h101, 12'd2, 2'b10, 4'd2, 3'd7));
    exp_q.push_back(mk(12'h106, 12'd7, 2'b01, 4'd0, 3'd3));
    exp_q.push_back(mk(12'h107, 12'd8, 2'b01, 4'd1, 3'd3));
    exp_q.push_back(mk(12'h108, 12'd9, 2'b01, 4'd2, 3'd3));
  endtask

  task automatic cfg_c();
    base = 12'h000; xlen = 8'd16; outx = 8'd7; rows = 8'd2;
    krow = 4'd2; kcol = 4'd1; stride = 2'd2; pad = 2'd0;
  endtask

  task automatic push_c();
    exp_q.push_back(mk(12'd0,  12'd0, 2'b11, 4'd0, 3'd7));
    exp_q.push_back(mk(12'd16, 12'd0, 2'b11, 4'd0, 3'd7));
    exp_q.push_back(mk(12'd32, 12'd0, 2'b11, 4'd0, 3'd7));
    exp_q.push_back(mk(12'd48, 12'd0, 2'b11, 4'd0, 3'd7));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!gi.o_GroupStart && t < 100);
      check("issue_seen", 64'(gi.o_GroupStart), 64'(1));
      if (!gi.o_GroupStart) return;
      @(posedge clk); #1;
      gi.i_Fifo_REn = 1'b1;
      @(posedge clk); #1;
      gi.i_Fifo_REn = 1'b0;
    end
  endtask

  task automatic wait_endf(input int lim);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!endf && t < lim);
    check("endf_set", 64'(endf), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  initial begin
    int snap;
    rst = 1'b1; start = 1'b0;
    gi.i_GroupLoadEnd = 1'b0; gi.i_Fifo_REn = 1'b0;
    cfg_a();
    repeat (3) @(posedge clk);
    #1;
    check("rst_endf", 64'(endf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gstart", 64'(gi.o_GroupStart), 64'(0));
    check("rst_base", 64'(gi.o_BaseAdder), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_endf", 64'(endf), 64'(0));

    // basic issue
    cfg_a(); push_a();
    gi.i_GroupLoadEnd = 1'b1;
    pulse_start();
    check("a_busy", 64'(busy), 64'(1));
    consume(6);
    wait_endf(20);
    check("a_idle_busy", 64'(busy), 64'(0));
    check("a_sb_empty", 64'(exp_q.size()), 64'(0));

    // backpressure, full-FIFO pop with pending push, pop on empty
    cfg_a();
    gi.i_GroupLoadEnd = 1'b0;
    pulse_start();
    check("b_endf_drop", 64'(endf), 64'(0));
    snap = n_issue;
    repeat (20) @(posedge clk);
    #1;
    check("b_fifo_full", 64'(dut.fifo_cnt_q), 64'(4));
    check("b_busy", 64'(busy), 64'(1));
    check("b_no_issue", 64'(n_issue - snap), 64'(0));
    push_a();
    gi.i_GroupLoadEnd = 1'b1;
    consume(1);
    check("b_full_pop_push_cnt", 64'(dut.fifo_cnt_q), 64'(4));
    consume(5);
    wait_endf(20);
    check("b_sb_empty", 64'(exp_q.size()), 64'(0));
    gi.i_Fifo_REn = 1'b1;
    @(posedge clk); #1;
    gi.i_Fifo_REn = 1'b0;
    @(posedge clk); #1;
    check("b_empty_pop_cnt", 64'(dut.fifo_cnt_q), 64'(0));
    check("b_empty_pop_endf", 64'(endf), 64'(1));
    check("b_empty_pop_busy", 64'(busy), 64'(0));

    // row stepping
    cfg_c(); push_c();
    pulse_start();
    consume(4);
    wait_endf(20);
    check("c_sb_empty", 64'(exp_q.size()), 64'(0));

    // restart during GEN with two entries queued
    cfg_a();
    gi.i_GroupLoadEnd = 1'b0;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    check("d_two_queued", 64'(dut.fifo_cnt_q), 64'(2));
    cfg_c(); push_c();
    pulse_start();
    check("d_flushed", 64'(dut.fifo_cnt_q), 64'(0));
    check("d_busy", 64'(busy), 64'(1));
    gi.i_GroupLoadEnd = 1'b1;
    consume(4);
    wait_endf(20);
    check("d_sb_empty", 64'(exp_q.size()), 64'(0));

    // reset mid-DRAIN
    cfg_c(); push_c();
    pulse_start();
    consume(1);
    repeat (3) @(posedge clk);
    #1;
    check("e_drain_busy", 64'(busy), 64'(1));
    check("e_drain_endf", 64'(endf), 64'(0));
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("e_rst_base", 64'(gi.o_BaseAdder), 64'(0));
    check("e_rst_col", 64'(gi.o_InputCurCol), 64'(0));
    check("e_rst_flag", 64'(gi.o_PartFlag), 64'(0));
    check("e_rst_kc", 64'(gi.o_KerCol), 64'(0));
    check("e_rst_lc", 64'(gi.o_LastColNum), 64'(0));
    check("e_rst_gstart", 64'(gi.o_GroupStart), 64'(0));
    check("e_rst_endf", 64'(endf), 64'(0));
    check("e_rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/iagu_conv_baddr.md
IAGU_CONV_BADDR -- requirements
Module: iagu_conv_baddr

Interface
REQ-001 SHALL provide parameter ADDR_W, default 12, IOB address width.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, group-descriptor FIFO depth; power of two, at least 2.
REQ-003 SHALL have ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_AGUStart  in  1  one-cycle pulse; latches the configuration and (re)starts generation.
- i_IOB_Base  in  ADDR_W  IOB address of input row 0, column 0.
- i_Input_XLength  in  8  input row length in words, unpadded.
- i_OutXLength  in  8  output columns per row, 1..255.
- i_OutRows  in  8  output rows, at least 1.
- i_KerCol, i_KerRow  in  4 each  kernel width and height, at least 1.
- i_Stride  in  2  stride, at least 1.
- i_Pad  in  2  horizontal pad.
- i_GroupLoadEnd  in  1  downstream idle or finished its group.
- i_Fifo_REn  in  1  downstream pop of the head descriptor.
- o_BaseAdder  out  ADDR_W  head base address.
- o_InputCurCol  out  12  head padded input column.
- o_PartFlag  out  2  head flag: bit1 first part, bit0 last part.
- o_KerCol  out  4  head kernel column index.
- o_LastColNum  out  3  head part length, 1..7.
- o_GroupStart  out  1  one-cycle group issue pulse.
- o_BaseAdderEndf  out  1  all groups issued and popped.
- o_Busy  out  1  generation or drain in progress.

Function
REQ-004 SHALL latch all configuration inputs on i_AGUStart; configuration changes at any other time have no effect.
REQ-005 SHALL compute at start: NumParts = ceil(OutXLength/7); LastLen = OutXLength - 7*(NumParts-1).
REQ-006 SHALL generate descriptors in loop order, outermost first: out row r < OutRows, kernel row kr < KerRow, part p < NumParts, kernel column kc < KerCol.
REQ-007 SHALL compute descriptor fields as follows:
- InputCurCol = 7*p*Stride + kc.
- BaseAdder = IOB_Base + (r*Stride + kr)*Input_XLength + InputCurCol - Pad, modulo 2^ADDR_W.
- PartFlag = {p==0, p==NumParts-1}.
- LastColNum = LastLen if p is the last part, else 7.
- KerCol = kc.
REQ-008 SHALL form the row offset with running accumulators only, no multipliers: add Input_XLength per kr step and Stride*Input_XLength per r step.
REQ-009 SHALL push at most one descriptor per cycle, only when the FIFO is not full; the generator SHALL stall while the FIFO is full.
REQ-010 SHALL use FSM states IDLE, GEN, DRAIN and DONE, with transitions:
- IDLE to GEN on i_AGUStart.
- GEN to DRAIN after the final descriptor is pushed.
- DRAIN to DONE when the FIFO is empty and no group is issued.
- Any state to GEN on i_AGUStart.
REQ-011 SHALL present the FIFO head combinationally on the o_* descriptor outputs; they hold stable from issue until pop.
REQ-012 SHALL assert o_GroupStart for exactly one cycle when the FIFO is non-empty, i_GroupLoadEnd is 1, no group is issued, and the state is not IDLE or DONE; this sets the issued flag.
REQ-013 SHALL pop the head and clear the issued flag on i_Fifo_REn; i_Fifo_REn while the FIFO is empty SHALL be ignored.
REQ-014 SHALL push and pop in the same cycle when both occur, including when the FIFO is full.
REQ-015 SHALL NOT issue a new o_GroupStart in the cycle of i_Fifo_REn; the earliest re-issue is the following cycle.
REQ-016 SHALL hold o_BaseAdderEndf at 1 only in DONE; it SHALL drop the cycle after i_AGUStart.
REQ-017 SHALL drive o_Busy = 1 in GEN and DRAIN.
REQ-018 SHALL, on i_AGUStart mid-operation, flush the FIFO, clear the issued flag and restart from r=kr=p=kc=0 with the new configuration; the first push occurs the cycle after the start pulse.

Reset
REQ-019 SHALL on i_rst = 1 force the state to IDLE, empty the FIFO, clear all counters and accumulators and the issued flag, and drive all outputs to 0; this overrides i_AGUStart in the same cycle.

Verification
REQ-020 SHALL cover basic issue:
- Config: Base=0x100, XLength=14, OutXLength=10, OutRows=1, KerRow=1, KerCol=3, Stride=1, Pad=1.
- Expect 6 descriptors, in order (Base, CurCol, Flag, LastColNum): (0x0FF,0,10,7), (0x100,1,10,7), (0x101,2,10,7), (0x106,7,01,3), (0x107,8,01,3), (0x108,9,01,3).
- Expect o_BaseAdderEndf=1 after the 6th pop.
REQ-021 SHALL cover backpressure:
- Hold i_GroupLoadEnd=0 for 20 cycles.
- Expect the FIFO holds 4 entries, the generator stalls, and no o_GroupStart fires.
- On release, expect the order preserved and no descriptor lost or duplicated.
REQ-022 SHALL cover row stepping:
- Config: OutRows=2, KerRow=2, Stride=2, XLength=16, KerCol=1, OutXLength=7, Pad=0, Base=0.
- Expect descriptor BaseAdder values 0, 16, 32, 48.
- Expect each PartFlag=11 and each LastColNum=7.
REQ-023 SHALL cover simultaneous events:
- Pop on a full FIFO with a pending push: expect the count unchanged.
- i_Fifo_REn on an empty FIFO: expect no state change.
REQ-024 SHALL cover restart and reset:
- i_AGUStart during GEN with 2 entries queued: expect the flush, and the next head equals the first descriptor of the new configuration.
- i_rst mid-DRAIN: expect all outputs 0 on the next cycle.
